// File: rtl/io_bus_pkg.sv
// Shared definitions for the dma_io bus arbiter: default widths, command
// word layout and arbitration mode constants.
package io_bus_pkg;

    localparam int IO_AW = 14;
    localparam int IO_DW = 32;

    // Arbitration policies
    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Command word layout, MSB first: {rd, adr[AW-1:0], wdata[DW-1:0]}
    function automatic int cmd_w(input int aw, input int dw);
        return 1 + aw + dw;
    endfunction

    localparam int IO_CMD_W = 1 + IO_AW + IO_DW;

endpackage

// File: rtl/io_cmd_fifo.sv
// Per-master command FIFO. Full/empty derive from the registered occupancy
// counter, so they reflect start-of-cycle state; a push into a full FIFO is
// ignored even when the same cycle pops it.
module io_cmd_fifo
    import io_bus_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = IO_CMD_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int            PW       = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);
    assign dout  = mem[rptr_q];

    // Next pointer and occupancy values; pointers wrap modulo DEPTH
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        wptr_d  = do_push ? wptr_q + PW'(1) : wptr_q;
        rptr_d  = do_pop  ? rptr_q + PW'(1) : rptr_q;
        cnt_d   = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + (PW + 1)'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - (PW + 1)'(1);
        end
    end

    // Pointer and counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage; contents are meaningless while empty, so no reset needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_q] <= din;
        end
    end

endmodule

// File: rtl/io_bus_arb.sv
// N-master arbiter for the shared dma_io bus. Each master queues commands in
// its own FIFO; one command per cycle is granted (fixed priority or
// round-robin) and driven onto registered bus outputs. Read data coming back
// from the peripheral chain is steered to the issuing master via a shift
// register that tracks the master id of every issued read.
module io_bus_arb
    import io_bus_pkg::*;
#(
    parameter int NM     = 2,
    parameter int DEPTH  = 2,
    parameter int MODE   = MODE_RR,
    parameter int RD_LAT = 1,
    parameter int AW     = IO_AW,
    parameter int DW     = IO_DW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NM-1:0]     m_we,
    input  logic [NM*AW-1:0]  m_wadr,
    input  logic [NM*DW-1:0]  m_wdata,
    input  logic [NM-1:0]     m_radr_en,
    input  logic [NM*AW-1:0]  m_radr,
    output logic [NM*DW-1:0]  m_rdata,
    output logic [NM-1:0]     m_rvalid,
    output logic [NM-1:0]     m_full,
    output logic [NM-1:0]     m_err,
    output logic              io_we,
    output logic [AW-1:0]     io_wadr,
    output logic [DW-1:0]     io_wdata,
    output logic              io_radr_en,
    output logic [AW-1:0]     io_radr,
    input  logic [DW-1:0]     io_rdata
);

    localparam int CW = cmd_w(AW, DW);
    localparam int IW = (NM > 1) ? $clog2(NM) : 1;

    logic [NM-1:0]   push, pop, full, empty;
    logic [CW-1:0]   din  [NM];
    logic [CW-1:0]   dout [NM];
    logic [NM-1:0]   err_q, err_d;

    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   start, gnt_idx;
    logic            gnt_vld;
    logic [2*NM-1:0] req_x2;
    logic [NM-1:0]   req_rot;
    logic [CW-1:0]   sel;

    logic            io_we_q, io_we_d;
    logic            io_radr_en_q, io_radr_en_d;
    logic [AW-1:0]   io_wadr_q, io_wadr_d;
    logic [DW-1:0]   io_wdata_q, io_wdata_d;
    logic [AW-1:0]   io_radr_q, io_radr_d;
    logic [IW-1:0]   id_q, id_d;

    logic [RD_LAT-1:0] sr_vld_q, sr_vld_d;
    logic [IW-1:0]     sr_id_q [RD_LAT];
    logic [IW-1:0]     sr_id_d [RD_LAT];

    logic [NM*DW-1:0]  m_rdata_q, m_rdata_d;
    logic [NM-1:0]     m_rvalid_q, m_rvalid_d;

    for (genvar g = 0; g < NM; g++) begin : g_fifo
        io_cmd_fifo #(
            .DEPTH (DEPTH),
            .W     (CW)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[g]),
            .pop   (pop[g]),
            .din   (din[g]),
            .dout  (dout[g]),
            .full  (full[g]),
            .empty (empty[g])
        );
    end

    // Enqueue: a write wins over a simultaneous read; drops and collisions latch the error flag
    always_comb begin
        err_d = err_q;
        for (int i = 0; i < NM; i++) begin
            push[i] = (m_we[i] || m_radr_en[i]) && !full[i];
            din[i]  = m_we[i] ? {1'b0, m_wadr[i*AW +: AW], m_wdata[i*DW +: DW]}
                              : {1'b1, m_radr[i*AW +: AW], {DW{1'b0}}};
            if (((m_we[i] || m_radr_en[i]) && full[i]) || (m_we[i] && m_radr_en[i])) begin
                err_d[i] = 1'b1;
            end
        end
    end

    // Grant: priority encode the request vector rotated to start after the last grant
    always_comb begin
        int off;
        int sum;
        start = '0;
        if (MODE == MODE_RR && NM > 1) begin
            start = (last_q == IW'(NM - 1)) ? '0 : last_q + IW'(1);
        end
        req_x2  = {~empty, ~empty} >> start;
        req_rot = req_x2[NM-1:0];
        gnt_vld = |req_rot;
        off     = 0;
        for (int k = NM - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                off = k;
            end
        end
        sum = int'(start) + off;
        if (sum >= NM) begin
            sum = sum - NM;
        end
        gnt_idx = IW'(sum);
        last_d  = (MODE == MODE_RR && gnt_vld) ? gnt_idx : last_q;
        sel     = '0;
        for (int i = 0; i < NM; i++) begin
            pop[i] = gnt_vld && (gnt_idx == IW'(i));
            if (gnt_idx == IW'(i)) begin
                sel = dout[i];
            end
        end
    end

    // Bus output and read-return next state
    always_comb begin
        io_we_d      = 1'b0;
        io_radr_en_d = 1'b0;
        io_wadr_d    = io_wadr_q;
        io_wdata_d   = io_wdata_q;
        io_radr_d    = io_radr_q;
        id_d         = id_q;
        if (gnt_vld) begin
            if (sel[CW-1]) begin
                io_radr_en_d = 1'b1;
                io_radr_d    = sel[DW +: AW];
                id_d         = gnt_idx;
            end else begin
                io_we_d    = 1'b1;
                io_wadr_d  = sel[DW +: AW];
                io_wdata_d = sel[DW-1:0];
            end
        end

        // Stage 0 tags the read currently on the bus; the last stage lines up with io_rdata
        sr_vld_d[0] = io_radr_en_q;
        sr_id_d[0]  = id_q;
        for (int k = 1; k < RD_LAT; k++) begin
            sr_vld_d[k] = sr_vld_q[k-1];
            sr_id_d[k]  = sr_id_q[k-1];
        end

        m_rvalid_d = '0;
        m_rdata_d  = m_rdata_q;
        if (sr_vld_q[RD_LAT-1]) begin
            for (int i = 0; i < NM; i++) begin
                if (sr_id_q[RD_LAT-1] == IW'(i)) begin
                    m_rvalid_d[i]          = 1'b1;
                    m_rdata_d[i*DW +: DW]  = io_rdata;
                end
            end
        end
    end

    // All arbiter state; reset clears in-flight reads so nothing returns afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q        <= '0;
            last_q       <= IW'(NM - 1);
            io_we_q      <= 1'b0;
            io_radr_en_q <= 1'b0;
            io_wadr_q    <= '0;
            io_wdata_q   <= '0;
            io_radr_q    <= '0;
            id_q         <= '0;
            sr_vld_q     <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                sr_id_q[k] <= '0;
            end
            m_rdata_q    <= '0;
            m_rvalid_q   <= '0;
        end else begin
            err_q        <= err_d;
            last_q       <= last_d;
            io_we_q      <= io_we_d;
            io_radr_en_q <= io_radr_en_d;
            io_wadr_q    <= io_wadr_d;
            io_wdata_q   <= io_wdata_d;
            io_radr_q    <= io_radr_d;
            id_q         <= id_d;
            sr_vld_q     <= sr_vld_d;
            for (int k = 0; k < RD_LAT; k++) begin
                sr_id_q[k] <= sr_id_d[k];
            end
            m_rdata_q    <= m_rdata_d;
            m_rvalid_q   <= m_rvalid_d;
        end
    end

    assign m_full     = full;
    assign m_err      = err_q;
    assign m_rdata    = m_rdata_q;
    assign m_rvalid   = m_rvalid_q;
    assign io_we      = io_we_q;
    assign io_wadr    = io_wadr_q;
    assign io_wdata   = io_wdata_q;
    assign io_radr_en = io_radr_en_q;
    assign io_radr    = io_radr_q;

endmodule
